// File: rtl/mastermind_round_ctrl.sv
// Game-round sequencer: gates master loading, grades guesses over an 8-cycle pass, tracks rounds and win/lose.
// Optional feature: define ROUND_LIMIT_EN to end the game as lost after MAX_ROUNDS non-winning guesses.
module mastermind_round_ctrl #(
  parameter int MAX_ROUNDS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       startGame,
  input  logic       masterLoaded,
  input  logic [2:0] master0,
  input  logic [2:0] master1,
  input  logic [2:0] master2,
  input  logic [2:0] master3,
  input  logic [2:0] guess0,
  input  logic [2:0] guess1,
  input  logic [2:0] guess2,
  input  logic [2:0] guess3,
  input  logic       guessSubmit,
  output logic       gamePlaying,
  output logic       resetMaster,
  output logic       gradeValid,
  output logic [2:0] znarly,
  output logic [2:0] zood,
  output logic [3:0] roundNum,
  output logic       guessError,
  output logic       won,
  output logic       lost
);

`ifdef ROUND_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
  if (MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_max_rounds
    $error("MAX_ROUNDS must be within 1..15");
  end
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [3:0] ROUND_LIMIT = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {SETUP, PLAY, GRADE, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       step, step_n;
  logic [3:0][2:0]  gq, gq_n;
  logic [2:0]       exact, exact_n, common, common_n;
  logic [2:0]       znarly_n, zood_n;
  logic [3:0]       round_n;
  logic             won_n, lost_n, grade_pulse, err_pulse;
  logic [3:0][2:0]  mst, gin;

  assign mst = {master3, master2, master1, master0};
  assign gin = {guess3, guess2, guess1, guess0};

  function automatic logic [2:0] count_of(input logic [3:0][2:0] s, input logic [2:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++)
      if (s[i] == v) c = c + 3'd1;
    return c;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    state_n     = state;
    step_n      = step;
    gq_n        = gq;
    exact_n     = exact;
    common_n    = common;
    znarly_n    = znarly;
    zood_n      = zood;
    round_n     = roundNum;
    won_n       = won;
    lost_n      = lost;
    grade_pulse = 1'b0;
    err_pulse   = 1'b0;
    if (startGame) begin
      state_n  = SETUP;
      step_n   = '0;
      round_n  = '0;
      znarly_n = '0;
      zood_n   = '0;
      won_n    = 1'b0;
      lost_n   = 1'b0;
    end else begin
      case (state)
        SETUP: if (masterLoaded) state_n = PLAY;
        PLAY: begin
          if (guessSubmit) begin
            if (guess0 != 3'd0 && guess1 != 3'd0 && guess2 != 3'd0 && guess3 != 3'd0) begin
              gq_n     = gin;
              round_n  = (roundNum == 4'd15) ? 4'd15 : roundNum + 4'd1;
              step_n   = '0;
              exact_n  = '0;
              common_n = '0;
              state_n  = GRADE;
            end else begin
              err_pulse = 1'b1;
            end
          end
        end
        GRADE: begin
          step_n = step + 4'd1;
          if (step == 4'd0) begin
            for (int i = 0; i < 4; i++)
              if (gq[i] == mst[i]) exact_n = exact_n + 3'd1;
          end else if (step <= 4'd7) begin
            common_n = common + min3(count_of(gq, step[2:0]), count_of(mst, step[2:0]));
          end else begin
            // report edge: publish the grade and decide where the round goes
            grade_pulse = 1'b1;
            znarly_n    = exact;
            zood_n      = common - exact;
            step_n      = '0;
            if (exact == 3'd4) begin
              won_n   = 1'b1;
              state_n = DONE;
            end else if (LIMIT_EN && roundNum == ROUND_LIMIT) begin
              lost_n  = 1'b1;
              state_n = DONE;
            end else begin
              state_n = PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= SETUP;
      step        <= '0;
      gq          <= '0;
      exact       <= '0;
      common      <= '0;
      znarly      <= '0;
      zood        <= '0;
      roundNum    <= '0;
      won         <= 1'b0;
      lost        <= 1'b0;
      gamePlaying <= 1'b0;
      resetMaster <= 1'b0;
      gradeValid  <= 1'b0;
      guessError  <= 1'b0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      gq          <= gq_n;
      exact       <= exact_n;
      common      <= common_n;
      znarly      <= znarly_n;
      zood        <= zood_n;
      roundNum    <= round_n;
      won         <= won_n;
      lost        <= lost_n;
      gamePlaying <= (state_n == PLAY) || (state_n == GRADE);
      resetMaster <= startGame;
      gradeValid  <= grade_pulse;
      guessError  <= err_pulse;
    end
  end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Directed bench for mastermind_round_ctrl: vector table of whole games plus hand sequences for corner cases.
module tb_mastermind_round_ctrl;
  logic       CLOCK_50 = 1'b0;
  logic       reset, startGame, masterLoaded, guessSubmit;
  logic [2:0] master0, master1, master2, master3;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       gamePlaying, resetMaster, gradeValid, guessError, won, lost;
  logic [2:0] znarly, zood;
  logic [3:0] roundNum;

  int total = 0;
  int bad   = 0;

  mastermind_round_ctrl #(.MAX_ROUNDS(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .startGame(startGame), .masterLoaded(masterLoaded),
    .master0(master0), .master1(master1), .master2(master2), .master3(master3),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .guessSubmit(guessSubmit), .gamePlaying(gamePlaying), .resetMaster(resetMaster),
    .gradeValid(gradeValid), .znarly(znarly), .zood(zood), .roundNum(roundNum),
    .guessError(guessError), .won(won), .lost(lost)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [2:0] m0, m1, m2, m3;
    logic [2:0] g0, g1, g2, g3;
    logic [2:0] ez, ezo;
    logic       ew;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_master(input logic [2:0] a, b, c, d);
    master0 = a; master1 = b; master2 = c; master3 = d;
  endtask

  task automatic set_guess(input logic [2:0] a, b, c, d);
    guess0 = a; guess1 = b; guess2 = c; guess3 = d;
  endtask

  task automatic submit();
    guessSubmit = 1'b1;
    tick();
    guessSubmit = 1'b0;
  endtask

  // ticks until gradeValid is seen; -1 if it never comes within the budget
  task automatic wait_grade(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (gradeValid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic new_game();
    startGame = 1'b1;
    masterLoaded = 1'b0;
    tick();
    startGame = 1'b0;
  endtask

  initial begin
    int n, gv;
    vecs[0] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 1'b0};
    vecs[1] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd2, 3'd1, 3'd3, 3'd1, 3'd2, 1'b0};
    vecs[2] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd0, 1'b1};
    vecs[3] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6, 3'd5, 3'd7, 3'd2, 3'd0, 1'b0};
    vecs[4] = '{3'd5, 3'd6, 3'd7, 3'd1, 3'd1, 3'd5, 3'd6, 3'd7, 3'd0, 3'd4, 1'b0};
    vecs[5] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 1'b0};
    vecs[6] = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0};
    vecs[7] = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd0, 1'b1};

    reset = 1'b1; startGame = 1'b0; masterLoaded = 1'b0; guessSubmit = 1'b0;
    set_master(0, 0, 0, 0);
    set_guess(0, 0, 0, 0);
    #12;
    chk("rst_gamePlaying", gamePlaying, 0);
    chk("rst_resetMaster", resetMaster, 0);
    chk("rst_gradeValid", gradeValid, 0);
    chk("rst_znarly", znarly, 0);
    chk("rst_zood", zood, 0);
    chk("rst_roundNum", roundNum, 0);
    chk("rst_guessError", guessError, 0);
    chk("rst_won", won, 0);
    chk("rst_lost", lost, 0);
    reset = 1'b0;
    tick();

    // load, reject a guess with an empty slot, then ignore a submit mid-grade
    set_master(1, 2, 3, 4);
    masterLoaded = 1'b1;
    tick();
    chk("load_gamePlaying", gamePlaying, 1);
    set_guess(0, 2, 3, 4);
    submit();
    chk("rej_guessError", guessError, 1);
    chk("rej_roundNum", roundNum, 0);
    tick();
    chk("rej_guessError_pulse", guessError, 0);
    chk("rej_gradeValid", gradeValid, 0);
    chk("rej_gamePlaying", gamePlaying, 1);
    set_guess(4, 3, 2, 1);
    submit();
    chk("acc_roundNum", roundNum, 1);
    submit();
    chk("grade_submit_noerr", guessError, 0);
    wait_grade(n);
    chk("grade_latency_after_ignored", n, 8);
    chk("g1_znarly", znarly, 0);
    chk("g1_zood", zood, 4);
    chk("g1_roundNum", roundNum, 1);
    chk("g1_gamePlaying", gamePlaying, 1);

    // second non-winning guess hits the round limit when enabled
    submit();
    wait_grade(n);
    chk("g2_latency", n, 9);
    chk("g2_roundNum", roundNum, 2);
`ifdef ROUND_LIMIT_EN
    chk("g2_lost", lost, 1);
    chk("g2_gamePlaying", gamePlaying, 0);
`else
    chk("g2_lost", lost, 0);
    chk("g2_gamePlaying", gamePlaying, 1);
`endif

    // startGame clears state; then abort a grade in flight
    new_game();
    chk("sg_resetMaster", resetMaster, 1);
    chk("sg_roundNum", roundNum, 0);
    chk("sg_zood", zood, 0);
    chk("sg_lost", lost, 0);
    chk("sg_gamePlaying", gamePlaying, 0);
    tick();
    chk("sg_resetMaster_pulse", resetMaster, 0);
    masterLoaded = 1'b1;
    tick();
    chk("sg_reload_gamePlaying", gamePlaying, 1);
    set_guess(1, 2, 3, 4);
    submit();
    tick();
    tick();
    new_game();
    chk("abort_resetMaster", resetMaster, 1);
    chk("abort_roundNum", roundNum, 0);
    chk("abort_gamePlaying", gamePlaying, 0);
    gv = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (gradeValid) gv++;
    end
    chk("abort_no_gradeValid", gv, 0);
    chk("abort_won", won, 0);
    chk("abort_setup_idle", gamePlaying, 0);

    for (int i = 0; i < 8; i++) begin
      new_game();
      set_master(vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].m3);
      masterLoaded = 1'b1;
      tick();
      chk($sformatf("v%0d_play", i), gamePlaying, 1);
      set_guess(vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3);
      submit();
      chk($sformatf("v%0d_roundNum", i), roundNum, 1);
      wait_grade(n);
      chk($sformatf("v%0d_latency", i), n, 9);
      chk($sformatf("v%0d_znarly", i), znarly, vecs[i].ez);
      chk($sformatf("v%0d_zood", i), zood, vecs[i].ezo);
      chk($sformatf("v%0d_won", i), won, vecs[i].ew);
      chk($sformatf("v%0d_gamePlaying", i), gamePlaying, !vecs[i].ew);
      tick();
      chk($sformatf("v%0d_gradeValid_pulse", i), gradeValid, 0);
    end

    // asynchronous reset while in PLAY with non-zero outputs
    new_game();
    set_master(1, 2, 3, 4);
    masterLoaded = 1'b1;
    tick();
    set_guess(4, 3, 2, 1);
    submit();
    wait_grade(n);
    chk("ar_pre_zood", zood, 4);
    #2 reset = 1'b1;
    #1;
    chk("ar_zood", zood, 0);
    chk("ar_roundNum", roundNum, 0);
    chk("ar_gamePlaying", gamePlaying, 0);
    chk("ar_gradeValid", gradeValid, 0);
    #2 reset = 1'b0;
    masterLoaded = 1'b0;
    tick();
    chk("ar_setup", gamePlaying, 0);
    masterLoaded = 1'b1;
    tick();
    chk("ar_setup_to_play", gamePlaying, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
